// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: FSM state encoding and y_select_next codes for the scan sequencer.
package scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STEP = 2'd2, DONE = 2'd3} state_t;
  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_INC  = 2'd1;
  localparam logic [1:0] SEL_ADD  = 2'd2;
  localparam logic [1:0] SEL_SUB  = 2'd3;
endpackage

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: sequences the y/s bit-scan datapath (load, N_ITER steps, done pulse).
// SCAN_EARLY_STOP_EN: when defined, a STEP with flag=1 ends the operation.
module scan_seq_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int         N_ITER = 8,
  parameter logic [1:0] S_STEP = 2'd1,
  parameter int         CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       hold,
  input  logic       b,
  input  logic       flag,
  output logic [1:0] y_select_next,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       s_en,
  output logic       y_store_x,
  output logic       s_add,
  output logic       s_zero,
  output logic       busy,
  output logic       done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic mode_r;
  logic last;
`ifdef SCAN_EARLY_STOP_EN
  assign last = (cnt == CNT_W'(N_ITER - 1)) || flag;
`else
  logic unused_flag;
  assign unused_flag = flag;
  assign last = cnt == CNT_W'(N_ITER - 1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) mode_r <= mode;
      cnt <= (state == LOAD) ? '0 : (state == STEP && !hold) ? cnt + 1'b1 : cnt;
    end
  end
  always_comb begin
    state_n       = state;
    y_select_next = SEL_HOLD;
    s_step        = 2'd0;
    y_en          = 1'b0;
    s_en          = 1'b0;
    y_store_x     = 1'b0;
    s_add         = 1'b1;
    s_zero        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: begin
        y_store_x = 1'b1;
        y_en      = 1'b1;
        s_zero    = 1'b1;
        s_en      = 1'b1;
        busy      = 1'b1;
        state_n   = STEP;
      end
      STEP: begin
        busy          = 1'b1;
        s_step        = S_STEP;
        y_select_next = mode_r ? (b ? SEL_INC : SEL_HOLD) : (b ? SEL_ADD : SEL_SUB);
        y_en          = !hold;
        s_en          = !hold;
        state_n       = (!hold && last) ? DONE : STEP;
      end
      default: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
endmodule
